// File: rtl/machine_mode_types_pkg.sv
// rtl/machine_mode_types_pkg.sv - shared machine-mode cause codes, mtvec modes, trap FSM states, mstatus fields
package machine_mode_types_pkg;

    localparam logic [4:0] CAUSE_MSI    = 5'd3;
    localparam logic [4:0] CAUSE_MTI    = 5'd7;
    localparam logic [4:0] EXT_IRQ_BASE = 5'd16;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'b00,
        MTVEC_VECTORED = 2'b01
    } mtvec_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        COMMIT = 2'd2,
        RET    = 2'd3
    } trap_state_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/irq_sync_latch.sv
// rtl/irq_sync_latch.sv - multi-flop synchroniser with optional rising-edge pending latch
module irq_sync_latch #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_async,
    input  logic clr,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   edge_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // shift the asynchronous line through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_async};
        end
    end

    // remember a 0->1 of the synchronised line until the trap for it commits; a new edge beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_prev_q <= 1'b0;
            edge_q      <= 1'b0;
        end else begin
            sync_prev_q <= sync_out;
            if (sync_out && !sync_prev_q) begin
                edge_q <= 1'b1;
            end else if (clr) begin
                edge_q <= 1'b0;
            end
        end
    end

    assign pending = EDGE_MODE ? edge_q : sync_out;

endmodule

// File: rtl/prv_trap_unit.sv
// rtl/prv_trap_unit.sv - trap and interrupt sequencer between the CSR file and the pipeline
module prv_trap_unit
    import machine_mode_types_pkg::*;
#(
    parameter int                 NUM_IRQ     = 4,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE    = '0,
    parameter int                 SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               timer_int,
    input  logic               soft_int,
    input  logic               ex_valid,
    input  logic [4:0]         ex_cause,
    input  logic [31:0]        ex_epc,
    input  logic [31:0]        ex_badaddr,
    input  logic               mret,
    input  logic [31:0]        int_epc,
    input  logic               pipe_ready,
    input  logic [31:0]        mstatus,
    input  logic [31:0]        mie,
    input  logic [31:0]        mip,
    input  logic [31:0]        mtvec,
    input  logic [31:0]        mepc,
    output logic               trap_req,
    output logic               trap_ack,
    output logic [31:0]        redirect_pc,
    output logic               mip_rup,
    output logic [31:0]        mip_next,
    output logic               mcause_rup,
    output logic [31:0]        mcause_next,
    output logic               mepc_rup,
    output logic [31:0]        mepc_next,
    output logic               mbadaddr_rup,
    output logic [31:0]        mbadaddr_next,
    output logic               mstatus_rup,
    output logic [31:0]        mstatus_next
);

    localparam logic [31:0] PEND_MASK =
        (((32'h1 << NUM_IRQ) - 32'h1) << EXT_IRQ_BASE) | (32'h1 << CAUSE_MSI) | (32'h1 << CAUSE_MTI);

    trap_state_e        state_q, state_d;
    logic               is_int_q;
    logic [4:0]         code_q;
    logic [31:0]        epc_q;
    logic [31:0]        badaddr_q;
    logic [NUM_IRQ-1:0] irq_pend;
    logic [31:0]        pend_vec;
    logic [31:0]        enabled;
    logic               sel_valid;
    logic               sel_int;
    logic [4:0]         sel_code;
    logic [31:0]        trap_vector;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_irq
        logic clr;
        assign clr = (state_q == COMMIT) && is_int_q && (code_q == 5'(int'(EXT_IRQ_BASE) + i));
        irq_sync_latch #(
            .SYNC_STAGES(SYNC_STAGES),
            .EDGE_MODE  (IRQ_EDGE[i])
        ) u_sync (
            .clk      (CLK),
            .rst_n    (nRST),
            .irq_async(irq_in[i]),
            .clr      (clr),
            .pending  (irq_pend[i])
        );
    end

    // assemble the mip-shaped pending vector and mask it down to what may interrupt now
    always_comb begin
        pend_vec                                 = '0;
        pend_vec[CAUSE_MSI]                      = soft_int;
        pend_vec[CAUSE_MTI]                      = timer_int;
        pend_vec[int'(EXT_IRQ_BASE) +: NUM_IRQ]  = irq_pend;
        enabled = pend_vec & mie & {32{mstatus[MSTATUS_MIE]}};
    end

    // pick the winner: exception, then external channels low to high, then MSI, then MTI
    always_comb begin
        sel_valid = 1'b0;
        sel_int   = 1'b0;
        sel_code  = '0;
        if (ex_valid) begin
            sel_valid = 1'b1;
            sel_code  = ex_cause;
        end else begin
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if (enabled[int'(EXT_IRQ_BASE) + i]) begin
                    sel_valid = 1'b1;
                    sel_int   = 1'b1;
                    sel_code  = 5'(int'(EXT_IRQ_BASE) + i);
                end
            end
            if (!sel_valid && enabled[CAUSE_MSI]) begin
                sel_valid = 1'b1;
                sel_int   = 1'b1;
                sel_code  = CAUSE_MSI;
            end else if (!sel_valid && enabled[CAUSE_MTI]) begin
                sel_valid = 1'b1;
                sel_int   = 1'b1;
                sel_code  = CAUSE_MTI;
            end
        end
    end

    // trap FSM state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // freeze the winning cause when a trap is accepted so FLUSH cannot be disturbed by new events
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            is_int_q  <= 1'b0;
            code_q    <= '0;
            epc_q     <= '0;
            badaddr_q <= '0;
        end else if (state_q == IDLE && sel_valid) begin
            is_int_q  <= sel_int;
            code_q    <= sel_code;
            epc_q     <= sel_int ? int_epc : ex_epc;
            badaddr_q <= sel_int ? 32'h0 : ex_badaddr;
        end
    end

    // mip mirror refreshed every cycle once out of reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mip_rup  <= 1'b0;
            mip_next <= '0;
        end else begin
            mip_rup  <= 1'b1;
            mip_next <= (mip & ~PEND_MASK) | pend_vec;
        end
    end

    assign trap_vector = {mtvec[31:2], 2'b00} +
                         ((is_int_q && mtvec[1:0] == MTVEC_VECTORED) ? {25'b0, code_q, 2'b00} : 32'h0);

    // next state plus the handshake and CSR update strobes for the current state
    always_comb begin
        state_d       = state_q;
        trap_req      = 1'b0;
        trap_ack      = 1'b0;
        redirect_pc   = '0;
        mcause_rup    = 1'b0;
        mcause_next   = '0;
        mepc_rup      = 1'b0;
        mepc_next     = '0;
        mbadaddr_rup  = 1'b0;
        mbadaddr_next = '0;
        mstatus_rup   = 1'b0;
        mstatus_next  = '0;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = FLUSH;
                end else if (mret) begin
                    state_d = RET;
                end
            end
            FLUSH: begin
                trap_req = 1'b1;
                if (pipe_ready) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                trap_ack      = 1'b1;
                redirect_pc   = trap_vector;
                mcause_rup    = 1'b1;
                mcause_next   = {is_int_q, 26'b0, code_q};
                mepc_rup      = 1'b1;
                mepc_next     = {epc_q[31:2], 2'b00};
                mbadaddr_rup  = !is_int_q;
                mbadaddr_next = badaddr_q;
                mstatus_rup   = 1'b1;
                mstatus_next  = mstatus;
                mstatus_next[MSTATUS_MPIE]                  = mstatus[MSTATUS_MIE];
                mstatus_next[MSTATUS_MIE]                   = 1'b0;
                mstatus_next[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                state_d       = IDLE;
            end
            RET: begin
                trap_ack     = 1'b1;
                redirect_pc  = mepc;
                mstatus_rup  = 1'b1;
                mstatus_next = mstatus;
                mstatus_next[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
                mstatus_next[MSTATUS_MPIE] = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
